// File: rtl/fp_op_pkg.sv
// Shared definitions for the float operation master and its request FIFO.
package fp_op_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    // Quiet NaN pattern, used by benches as a "no result" marker.
    localparam logic [31:0] QNAN = 32'hFFC00000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        RESP   = 3'd4
    } state_t;

endpackage

// File: rtl/fp_req_fifo.sv
// Request FIFO: registered storage, combinational head read, wrap-bit pointers.
module fp_req_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      diff;
    logic             do_push;
    logic             do_pop;

    // Same index with opposite wrap bits means every slot is occupied.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign diff    = wr_ptr - rd_ptr;
    assign count   = CNT_W'(diff);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // Pointer update; a simultaneous push and pop leaves the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fp_op_master.sv
// Initiator for the stb/ack operand protocol of the float adder and multiplier.
// Requests are queued, issued one at a time (a, b, then z), and returned in order.
module fp_op_master
    import fp_op_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data_a,
    input  logic [DATA_WIDTH-1:0] i_data_b,
    input  logic                  i_op,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_op,
    output logic [CNT_W-1:0]      o_count,
    output logic [DATA_WIDTH-1:0] add_a,
    output logic [DATA_WIDTH-1:0] add_b,
    output logic                  add_a_stb,
    output logic                  add_b_stb,
    input  logic                  add_a_ack,
    input  logic                  add_b_ack,
    input  logic [DATA_WIDTH-1:0] add_z,
    input  logic                  add_z_stb,
    output logic                  add_z_ack,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    output logic                  mul_a_stb,
    output logic                  mul_b_stb,
    input  logic                  mul_a_ack,
    input  logic                  mul_b_ack,
    input  logic [DATA_WIDTH-1:0] mul_z,
    input  logic                  mul_z_stb,
    output logic                  mul_z_ack
);

    localparam int FW = 2*DATA_WIDTH + 1;

    state_t                state;
    logic                  op_sel;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    logic [FW-1:0]         fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    logic                  sel_mul;
    logic                  sel_a_ack;
    logic                  sel_b_ack;
    logic                  sel_z_stb;
    logic [DATA_WIDTH-1:0] sel_z;

    // Hold off the core during reset so nothing is queued into a clearing FIFO.
    assign o_ready = !fifo_full && !rst;
    assign push    = i_valid && o_ready;
    assign pop     = (state == IDLE) && !fifo_empty;

    fp_req_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata ({i_op, i_data_a, i_data_b}),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (o_count)
    );

    // Handshake steering: only the unit chosen by the latched op sees stb/ack.
    assign sel_mul   = (op_sel == OP_MUL);
    assign add_a_stb = (state == SEND_A) && !sel_mul;
    assign add_b_stb = (state == SEND_B) && !sel_mul;
    assign add_z_ack = (state == WAIT_Z) && !sel_mul;
    assign mul_a_stb = (state == SEND_A) &&  sel_mul;
    assign mul_b_stb = (state == SEND_B) &&  sel_mul;
    assign mul_z_ack = (state == WAIT_Z) &&  sel_mul;
    assign sel_a_ack = sel_mul ? mul_a_ack : add_a_ack;
    assign sel_b_ack = sel_mul ? mul_b_ack : add_b_ack;
    assign sel_z_stb = sel_mul ? mul_z_stb : add_z_stb;
    assign sel_z     = sel_mul ? mul_z     : add_z;

    // Operands go to both units; the strobes decide which one actually consumes them.
    assign add_a = op_a;
    assign add_b = op_b;
    assign mul_a = op_a;
    assign mul_b = op_b;

    // Operand latch at pop time; pure data, so no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            op_a <= fifo_head[2*DATA_WIDTH-1:DATA_WIDTH];
            op_b <= fifo_head[DATA_WIDTH-1:0];
        end
    end

    // Sequencer: pop, send a, send b, collect z, present result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_sel  <= OP_ADD;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_op    <= OP_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        op_sel <= fifo_head[FW-1];
                        state  <= SEND_A;
                    end
                end
                SEND_A: begin
                    if (sel_a_ack) state <= SEND_B;
                end
                SEND_B: begin
                    if (sel_b_ack) state <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (sel_z_stb) begin
                        o_data  <= sel_z;
                        o_op    <= op_sel;
                        o_valid <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_op_master.sv
// Directed bench for fp_op_master with a behavioural float adder/multiplier slave.
module tb_fp_op_master;
    import fp_op_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic             i_valid;
    logic             o_ready;
    logic [DW-1:0]    i_data_a;
    logic [DW-1:0]    i_data_b;
    logic             i_op;
    logic             o_valid;
    logic             i_ready;
    logic [DW-1:0]    o_data;
    logic             o_op;
    logic [CNT_W-1:0] o_count;
    logic [DW-1:0]    add_a, add_b, add_z, mul_a, mul_b, mul_z;
    logic             add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
    logic             mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;

    fp_op_master #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_data_a(i_data_a), .i_data_b(i_data_b), .i_op(i_op),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_op(o_op),
        .o_count(o_count),
        .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
        .add_a_ack(add_a_ack), .add_b_ack(add_b_ack), .add_z(add_z),
        .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
        .mul_a(mul_a), .mul_b(mul_b), .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_a_ack(mul_a_ack), .mul_b_ack(mul_b_ack), .mul_z(mul_z),
        .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] z;
    } vec_t;

    vec_t vecs [16];
    vec_t exp_q [$];

    int n_chk;
    int n_fail;
    int max_dly;
    bit z_hold;
    int add_act;
    int mul_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Single-precision <-> real conversion for normal numbers and zero.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(f[30:23]) - 11'd127 + 11'd1023;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [7:0]  e8;
        if (r == 0.0) return 32'd0;
        d  = $realtobits(r);
        e8 = 8'(d[62:52] - 11'd1023 + 11'd127);
        return {d[63], e8, d[51:29]};
    endfunction

    function automatic logic [31:0] fp_model(input logic u, input logic [31:0] a, input logic [31:0] b);
        if (u) return r2f(f2r(a) * f2r(b));
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic int pick_dly();
        if (max_dly == 0) return 0;
        return int'($urandom_range(0, max_dly));
    endfunction

    function automatic logic cur_a_stb(input logic u);
        return u ? mul_a_stb : add_a_stb;
    endfunction
    function automatic logic cur_b_stb(input logic u);
        return u ? mul_b_stb : add_b_stb;
    endfunction
    function automatic logic cur_z_ack(input logic u);
        return u ? mul_z_ack : add_z_ack;
    endfunction
    function automatic logic [31:0] cur_a(input logic u);
        return u ? mul_a : add_a;
    endfunction
    function automatic logic [31:0] cur_b(input logic u);
        return u ? mul_b : add_b;
    endfunction

    task automatic set_a_ack(input logic u, input logic v);
        if (u) mul_a_ack = v; else add_a_ack = v;
    endtask
    task automatic set_b_ack(input logic u, input logic v);
        if (u) mul_b_ack = v; else add_b_ack = v;
    endtask
    task automatic set_z(input logic u, input logic v, input logic [31:0] z);
        if (u) begin mul_z_stb = v; mul_z = z; end
        else   begin add_z_stb = v; add_z = z; end
    endtask

    // Behavioural slave for both units (only one operation is ever outstanding).
    initial begin : slave
        int st, cnt, dly;
        logic u, last;
        logic [31:0] ra, rb, res;
        st = 0; cnt = 0; dly = 0; u = 1'b0; last = 1'b0; ra = '0; rb = '0; res = '0;
        add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; add_z = '0;
        mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0; mul_z = '0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                st = 0;
                add_a_ack = 0; add_b_ack = 0; add_z_stb = 0;
                mul_a_ack = 0; mul_b_ack = 0; mul_z_stb = 0;
            end else begin
                case (st)
                    0: if (add_a_stb || mul_a_stb) begin
                        u = mul_a_stb; ra = cur_a(u); dly = pick_dly(); cnt = 0;
                        if (dly == 0) begin set_a_ack(u, 1'b1); st = 2; end else st = 1;
                    end
                    1: begin
                        chk("a_stb_held", 32'(cur_a_stb(u)), 32'd1);
                        chk("a_stable", cur_a(u), ra);
                        cnt++;
                        if (cnt >= dly) begin set_a_ack(u, 1'b1); st = 2; end
                    end
                    2: begin
                        set_a_ack(u, 1'b0);
                        chk("a_stb_drop", 32'(cur_a_stb(u)), 32'd0);
                        st = 3;
                    end
                    3: if (cur_b_stb(u)) begin
                        rb = cur_b(u); dly = pick_dly(); cnt = 0;
                        if (dly == 0) begin set_b_ack(u, 1'b1); st = 5; end else st = 4;
                    end
                    4: begin
                        chk("b_stb_held", 32'(cur_b_stb(u)), 32'd1);
                        chk("b_stable", cur_b(u), rb);
                        cnt++;
                        if (cnt >= dly) begin set_b_ack(u, 1'b1); st = 5; end
                    end
                    5: begin
                        set_b_ack(u, 1'b0);
                        chk("b_stb_drop", 32'(cur_b_stb(u)), 32'd0);
                        res = fp_model(u, ra, rb); dly = pick_dly(); cnt = 0;
                        st = 6;
                    end
                    6: if (!z_hold) begin
                        if (cnt >= dly) begin
                            set_z(u, 1'b1, res); last = cur_z_ack(u); st = 7;
                        end else cnt++;
                    end
                    default: begin
                        if (last) begin
                            set_z(u, 1'b0, res);
                            chk("z_ack_drop", 32'(cur_z_ack(u)), 32'd0);
                            st = 0;
                        end else last = cur_z_ack(u);
                    end
                endcase
            end
        end
    end

    // Response consumer: every accepted result must match the next queued expectation.
    initial begin : consumer
        vec_t e;
        forever begin
            @(negedge clk); #1;
            if (!rst && o_valid && i_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_result");
                else begin
                    e = exp_q.pop_front();
                    chk("o_data", o_data, e.z);
                    chk("o_op", 32'(o_op), 32'(e.op));
                end
            end
        end
    end

    // Activity monitor per unit.
    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (add_a_stb || add_b_stb || add_z_ack) add_act++;
                if (mul_a_stb || mul_b_stb || mul_z_ack) mul_act++;
            end
        end
    end

    task automatic push_req(input vec_t v);
        int t;
        t = 0;
        i_valid = 1'b1; i_data_a = v.a; i_data_b = v.b; i_op = v.op;
        while (!o_ready && t < 500) begin @(negedge clk); t++; end
        if (t >= 500) fail_now("push_timeout");
        @(negedge clk);
        i_valid = 1'b0;
        exp_q.push_back(v);
    endtask

    task automatic drain(input int limit);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_valid) && t < limit) begin @(negedge clk); t++; end
        if (t >= limit) fail_now("drain_timeout");
    endtask

    function automatic logic [5:0] hs_vec();
        return {add_a_stb, add_b_stb, add_z_ack, mul_a_stb, mul_b_stb, mul_z_ack};
    endfunction

    initial begin : main
        int t;
        n_chk = 0; n_fail = 0; max_dly = 0; z_hold = 0; add_act = 0; mul_act = 0;
        rst = 1'b1; i_valid = 1'b0; i_data_a = '0; i_data_b = '0; i_op = 1'b0; i_ready = 1'b0;

        vecs[0]  = '{32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000};
        vecs[1]  = '{32'h40400000, 32'h40000000, OP_MUL, 32'h40C00000};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, OP_ADD, 32'h40000000};
        vecs[3]  = '{32'h40000000, 32'h40000000, OP_MUL, 32'h40800000};
        vecs[4]  = '{32'h40400000, 32'h3F800000, OP_ADD, 32'h40800000};
        vecs[5]  = '{32'h3F000000, 32'h40800000, OP_MUL, 32'h40000000};
        vecs[6]  = '{32'h40A00000, 32'h40A00000, OP_ADD, 32'h41200000};
        vecs[7]  = '{32'h40A00000, 32'h40000000, OP_MUL, 32'h41200000};
        vecs[8]  = '{32'hBF800000, 32'h40000000, OP_ADD, 32'h3F800000};
        vecs[9]  = '{32'hBF800000, 32'h40400000, OP_MUL, 32'hC0400000};
        vecs[10] = '{32'h3F000000, 32'h3F000000, OP_ADD, 32'h3F800000};
        vecs[11] = '{32'h41200000, 32'h41200000, OP_MUL, 32'h42C80000};
        vecs[12] = '{32'h41200000, 32'h40A00000, OP_ADD, 32'h41700000};
        vecs[13] = '{32'h3F000000, 32'h3F000000, OP_MUL, 32'h3E800000};
        vecs[14] = '{32'h40800000, 32'h40800000, OP_ADD, 32'h41000000};
        vecs[15] = '{32'h40C00000, 32'h3F000000, OP_MUL, 32'h40400000};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_o_ready", 32'(o_ready), 32'd0);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_count", 32'(o_count), 32'd0);
        chk("rst_o_data", o_data, 32'd0);
        chk("rst_o_op", 32'(o_op), 32'd0);
        chk("rst_hs", 32'(hs_vec()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_o_ready", 32'(o_ready), 32'd1);

        // Single add, multiplier must stay idle
        i_ready = 1'b1; add_act = 0; mul_act = 0;
        push_req(vecs[0]);
        drain(200);
        chk("add_used", 32'(add_act != 0), 32'd1);
        chk("mul_idle", 32'(mul_act), 32'd0);

        // Single mul, adder must stay idle
        add_act = 0; mul_act = 0;
        push_req(vecs[1]);
        drain(200);
        chk("mul_used", 32'(mul_act != 0), 32'd1);
        chk("add_idle", 32'(add_act), 32'd0);

        // Backpressure: result held, FIFO fills, sixth request waits
        i_ready = 1'b0;
        for (int i = 2; i < 7; i++) push_req(vecs[i]);
        t = 0;
        while (!o_valid && t < 100) begin @(negedge clk); t++; end
        chk("bp_valid", 32'(o_valid), 32'd1);
        i_valid = 1'b1; i_data_a = vecs[7].a; i_data_b = vecs[7].b; i_op = vecs[7].op;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_o_ready", 32'(o_ready), 32'd0);
            chk("bp_o_count", 32'(o_count), 32'd4);
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_o_data", o_data, vecs[2].z);
        end
        i_ready = 1'b1;
        t = 0;
        while (!o_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) fail_now("bp_release_timeout");
        @(negedge clk);
        i_valid = 1'b0;
        exp_q.push_back(vecs[7]);
        drain(500);
        chk("bp_count_end", 32'(o_count), 32'd0);

        // Random slave delays over 16 mixed operations
        max_dly = 7;
        for (int i = 0; i < 16; i++) push_req(vecs[i]);
        drain(5000);
        max_dly = 0;

        // Reset while waiting for z with three requests queued
        z_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_req(vecs[i]);
        t = 0;
        while (!(add_z_ack || mul_z_ack) && t < 100) begin @(negedge clk); t++; end
        chk("wz_reached", 32'(add_z_ack || mul_z_ack), 32'd1);
        chk("wz_count", 32'(o_count), 32'd3);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_hs", 32'(hs_vec()), 32'd0);
        chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_o_count", 32'(o_count), 32'd0);
        rst = 1'b0;
        z_hold = 1'b0;
        @(negedge clk);
        push_req(vecs[2]);
        drain(200);

        // FIFO wrap: 2*DEPTH+1 back-to-back requests
        for (int i = 0; i < 2*DEPTH+1; i++) push_req(vecs[i]);
        drain(1000);
        chk("wrap_count_end", 32'(o_count), 32'd0);
        chk("wrap_valid_end", 32'(o_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
